// File: rtl/seven_segment_scan_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package : display_pkg
// Brief   : Shared types and constants for the 7-segment scan controller.
// Rev     : 1.0
// ============================================================================
package display_pkg;

    typedef enum logic [1:0] {
        DARK = 2'd0,
        DEAD = 2'd1,
        ON   = 2'd2
    } scan_state_e;

    localparam logic [3:0] BLANK_NIBBLE = 4'hF;
    localparam logic [6:0] SEG_OFF      = 7'h7F;

endpackage
`default_nettype wire

// File: rtl/seven_segment_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
// Interface : seven_segment_scan_ctrl_if
// Brief     : Valid/ready frame-load channel into the scan controller.
// Rev       : 1.0
// ============================================================================
interface seven_segment_scan_ctrl_if #(
    parameter int NUM_DIGITS = 4
);
    logic                      load_valid;
    logic                      load_ready;
    logic [4*NUM_DIGITS-1:0]   load_value;

    modport master (
        output load_valid,
        output load_value,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  load_value,
        output load_ready
    );
endinterface
`default_nettype wire

// File: rtl/seven_segment_scan_ctrl_display.sv
`default_nettype none
// ============================================================================
// Module : seven_segment_display
// Brief  : BCD to active-low segment decoder, seg = {g,f,e,d,c,b,a}; 10..15 blank.
// Rev    : 1.0
// ============================================================================
module seven_segment_display
    import display_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_OFF;
        case (digit)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = SEG_OFF;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/seven_segment_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module : seven_segment_scan_ctrl
// Brief  : Multiplexed common-anode 7-seg scanner with dead-time and frame
//          double-buffering. Option macro: LEADING_ZERO_BLANK_EN.
// Rev    : 1.0
// ============================================================================
module seven_segment_scan_ctrl
    import display_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int PRESCALE    = 50000,
    parameter int DEAD_CYCLES = 500
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    seven_segment_scan_ctrl_if.slave  load_if,
    output logic [NUM_DIGITS-1:0]     an,
    output logic [3:0]                digit,
    output logic [6:0]                seg
);

    localparam int CNT_W   = $clog2(PRESCALE);
    localparam int IDX_W   = $clog2(NUM_DIGITS);
    localparam int FRAME_W = 4 * NUM_DIGITS;

    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] c_cnt_dead = CNT_W'(DEAD_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
    localparam logic [IDX_W-1:0] c_idx_last = IDX_W'(NUM_DIGITS - 1);
    localparam logic [IDX_W-1:0] c_idx_one  = IDX_W'(1);

    scan_state_e           state_q,   state_d;
    logic [CNT_W-1:0]      cnt_q,     cnt_d;
    logic [IDX_W-1:0]      idx_q,     idx_d;
    logic [FRAME_W-1:0]    staging_q, staging_d;
    logic [FRAME_W-1:0]    shadow_q,  shadow_d;
    logic                  pending_q, pending_d;
    logic [NUM_DIGITS-1:0] an_q,      an_d;
    logic [3:0]            digit_q,   digit_d;

    logic                  w_accept;
    logic                  w_commit;
    logic [FRAME_W-1:0]    w_upper;
    logic [3:0]            w_nibble;

    assign load_if.load_ready = ~pending_q;
    assign w_accept = load_if.load_valid & ~pending_q;
    // Frames swap only between scans (or while dark) so no frame ever tears.
    assign w_commit = (state_q == DARK) |
                      ((state_q == ON) & (cnt_q == c_cnt_last) & (idx_q == c_idx_last));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        if (!enable) begin
            state_d = DARK;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                DARK: begin
                    state_d = DEAD;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
                DEAD: begin
                    cnt_d = cnt_q + c_cnt_one;
                    if (cnt_q == c_cnt_dead) begin
                        state_d = ON;
                    end
                end
                ON: begin
                    if (cnt_q == c_cnt_last) begin
                        cnt_d   = '0;
                        idx_d   = (idx_q == c_idx_last) ? '0 : idx_q + c_idx_one;
                        state_d = DEAD;
                    end else begin
                        cnt_d = cnt_q + c_cnt_one;
                    end
                end
                default: begin
                    state_d = DARK;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        staging_d = staging_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        if (w_commit && pending_q) begin
            shadow_d  = staging_q;
            pending_d = 1'b0;
        end
        if (w_accept) begin
            staging_d = load_if.load_value;
            pending_d = 1'b1;
        end
    end

    // Outputs are computed from next-state so they line up with state_q.
    always_comb begin
        w_upper  = shadow_d >> {idx_d, 2'b00};
        w_nibble = w_upper[3:0];
`ifdef LEADING_ZERO_BLANK_EN
        if ((idx_d != '0) && (w_upper == '0)) begin
            w_nibble = BLANK_NIBBLE;
        end
`endif
        an_d    = (state_d == ON) ? ~(NUM_DIGITS'(1) << idx_d) : '1;
        digit_d = (state_d == DARK) ? BLANK_NIBBLE : w_nibble;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= DARK;
            cnt_q     <= '0;
            idx_q     <= '0;
            staging_q <= '0;
            shadow_q  <= '0;
            pending_q <= 1'b0;
            an_q      <= '1;
            digit_q   <= BLANK_NIBBLE;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            staging_q <= staging_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            an_q      <= an_d;
            digit_q   <= digit_d;
        end
    end

    assign an    = an_q;
    assign digit = digit_q;

    seven_segment_display u_decoder (
        .digit (digit_q),
        .seg   (seg)
    );

endmodule
`default_nettype wire

// File: tb/tb_seven_segment_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_seven_segment_scan_ctrl
// Brief  : Self-checking bench with a frame-position reference model.
// Rev    : 1.0
// ============================================================================
module tb_seven_segment_scan_ctrl;

    localparam int N = 4;
    localparam int P = 8;
    localparam int D = 2;

    int total = 0;
    int bad   = 0;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [3:0] an;
    logic [3:0] digit;
    logic [6:0] seg;

    seven_segment_scan_ctrl_if #(.NUM_DIGITS(N)) lif ();

    seven_segment_scan_ctrl #(
        .NUM_DIGITS  (N),
        .PRESCALE    (P),
        .DEAD_CYCLES (D)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  (enable),
        .load_if (lif.slave),
        .an      (an),
        .digit   (digit),
        .seg     (seg)
    );

    always #5 clk = ~clk;

    // Reference: dark flag plus cycles elapsed since the scan started.
    bit          m_dark;
    int          m_pos;
    bit          m_pending;
    bit          m_acc;
    logic [15:0] m_staging;
    logic [15:0] m_shadow;

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        logic [6:0] tbl [10];
        tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        return (n < 10) ? tbl[n] : 7'h7F;
    endfunction

    function automatic logic [3:0] exp_digit();
        int          slot;
        logic [15:0] up;
        if (m_dark) return 4'hF;
        slot = (m_pos / P) % N;
        up   = m_shadow >> (4 * slot);
`ifdef LEADING_ZERO_BLANK_EN
        if (slot > 0 && up == 16'h0) return 4'hF;
`endif
        return up[3:0];
    endfunction

    function automatic logic [3:0] exp_an();
        int slot;
        if (m_dark || (m_pos % P) < D) return 4'hF;
        slot = (m_pos / P) % N;
        return ~(4'b0001 << slot);
    endfunction

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        assert (got === exp)
        else begin
            bad++;
            $error("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        logic [3:0] ed;
        ed = exp_digit();
        check("an",         {12'h0, an},    {12'h0, exp_an()});
        check("digit",      {12'h0, digit}, {12'h0, ed});
        check("seg",        {9'h0, seg},    {9'h0, seg_of(ed)});
        check("load_ready", {15'h0, lif.load_ready}, {15'h0, ~m_pending});
    endtask

    task automatic model_reset();
        m_dark    = 1'b1;
        m_pos     = 0;
        m_pending = 1'b0;
        m_staging = '0;
        m_shadow  = '0;
    endtask

    task automatic step();
        bit commit;
        bit accept;
        @(posedge clk);
        m_acc = 1'b0;
        if (!rst_n) begin
            model_reset();
        end else begin
            commit = m_dark || ((m_pos % P) == P - 1 && ((m_pos / P) % N) == N - 1);
            accept = lif.load_valid && !m_pending;
            if (m_pending && commit) begin
                m_shadow  = m_staging;
                m_pending = 1'b0;
            end
            if (accept) begin
                m_staging = lif.load_value;
                m_pending = 1'b1;
                m_acc     = 1'b1;
            end
            if (!enable)     m_dark = 1'b1;
            else if (m_dark) begin m_dark = 1'b0; m_pos = 0; end
            else             m_pos++;
        end
        #1;
        check_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic load_once(input logic [15:0] v);
        lif.load_valid = 1'b1;
        lif.load_value = v;
        step();
        lif.load_valid = 1'b0;
    endtask

    task automatic load_hold(input logic [15:0] v);
        lif.load_valid = 1'b1;
        lif.load_value = v;
        m_acc = 1'b0;
        for (int i = 0; i < 3 * N * P && !m_acc; i++) step();
        total++;
        assert (m_acc) else begin
            bad++;
            $error("FAIL load_hold_timeout got=0 exp=1");
        end
        lif.load_valid = 1'b0;
    endtask

    initial begin
        rst_n          = 1'b1;
        enable         = 1'b0;
        lif.load_valid = 1'b0;
        lif.load_value = '0;
        model_reset();
        #2 rst_n = 1'b0;
        #1 check_all();
        run(3);
        rst_n = 1'b1;

        enable = 1'b1;
        load_once(16'h1234);
        run(2 * N * P + 4);

        run(12);
        load_once(16'h5678);
        run(N * P + 8);

        load_hold(16'h9999);
        load_hold(16'h0000);
        run(2 * N * P);

        run(11);
        load_once(16'h4321);
        run(2);
        enable = 1'b0;
        run(3);
        enable = 1'b1;
        run(N * P + 3);

        for (int i = 0; i < 4 * P && (m_dark || (m_pos % P) < D); i++) step();
        #3 rst_n = 1'b0;
        model_reset();
        #1 check_all();
        run(2);
        rst_n = 1'b1;
        run(4);

        for (int i = 0; i < 800; i++) begin
            enable         = ($urandom_range(0, 24) != 0);
            lif.load_valid = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 3) == 0) begin
                lif.load_value = 16'($urandom());
            end else begin
                for (int k = 0; k < N; k++) lif.load_value[4*k +: 4] = 4'($urandom_range(0, 9));
            end
            step();
        end

        enable = 1'b1;
        lif.load_valid = 1'b0;
        run(3);
        load_hold(16'h0070);
        run(3 * N * P);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
